// File: rtl/core_types_pkg.sv
// core_types_pkg: shared types for the data-memory path.
//   dmem_len_t       : access size code carried on req_len
//   dmem_rsp_state_t : responder FSM states
//   dmem_misaligned  : true when a half/word access is not naturally aligned
//   dmem_force_align : clears the low address bits a half/word access ignores
package core_types_pkg;

  typedef logic [1:0] dmem_len_t;
  localparam dmem_len_t LEN_WORD = 2'd0;
  localparam dmem_len_t LEN_BYTE = 2'd1;
  localparam dmem_len_t LEN_HALF = 2'd2;  // 2'd3 is reserved and behaves as a word

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_rsp_state_t;

  function automatic logic dmem_misaligned(input dmem_len_t len, input logic [1:0] lane);
    case (len)
      LEN_BYTE: return 1'b0;
      LEN_HALF: return lane[0];
      default:  return lane != 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] dmem_force_align(input dmem_len_t len, input logic [1:0] lane);
    case (len)
      LEN_BYTE: return lane;
      LEN_HALF: return {lane[1], 1'b0};
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between the M stage
// (master) and the data-memory responder (slave).
//   req_*  : request channel (valid/ready), mtype 0=load 1=store, len, unsigned,
//            byte address, right-aligned store data
//   rsp_*  : response channel (valid/ready), extended load data, misalign error
interface dmem_responder_if #(
  parameter int N_BITS = 32
);
  logic              req_vld;
  logic              req_rdy;
  logic              req_mtype;
  logic [1:0]        req_len;
  logic              req_unsigned;
  logic [N_BITS-1:0] req_addr;
  logic [N_BITS-1:0] req_data;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [N_BITS-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_vld, req_mtype, req_len, req_unsigned, req_addr, req_data, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_data, rsp_err
  );

  modport slave (
    input  req_vld, req_mtype, req_len, req_unsigned, req_addr, req_data, rsp_rdy,
    output req_rdy, rsp_vld, rsp_data, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: purely combinational byte-lane steering for 32-bit words.
//   Store path: st_len/st_lane/st_data -> wr_data (replicated across lanes)
//               and wr_be (byte enables).
//   Load path : ld_len/ld_lane/ld_unsigned/ld_word -> ld_data, the selected
//               byte/half right-aligned and sign- or zero-extended.
module dmem_lane_align
  import core_types_pkg::*;
(
  input  dmem_len_t   st_len,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  input  dmem_len_t   ld_len,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_bytes  [4];
  logic [15:0] ld_halves [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign ld_bytes[gi] = ld_word[gi*8 +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign ld_halves[gi] = ld_word[gi*16 +: 16];
    end
  endgenerate

  assign sel_byte = ld_bytes[ld_lane];
  assign sel_half = ld_halves[ld_lane[1]];

  // Replicating the store data lets the byte enables alone pick the lane.
  always_comb begin
    wr_data = st_data;
    wr_be   = 4'hF;
    case (st_len)
      LEN_BYTE: begin
        wr_data = {4{st_data[7:0]}};
        wr_be   = 4'b0001 << st_lane;
      end
      LEN_HALF: begin
        wr_data = {2{st_data[15:0]}};
        wr_be   = 4'b0011 << {st_lane[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_word;
    case (ld_len)
      LEN_BYTE: ld_data = {{24{~ld_unsigned & sel_byte[7]}}, sel_byte};
      LEN_HALF: ld_data = {{16{~ld_unsigned & sel_half[15]}}, sel_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: bench/FPGA data memory answering the M-stage load/store path.
// One request in flight; the access happens WAIT_CYCLES cycles after accept,
// then the response is held until the consumer takes it.
// Ports: clk, rst (asynchronous, active high), bus (dmem_responder_if.slave).
// Parameters: N_BITS (32), DEPTH_LOG2 (words = 2**DEPTH_LOG2), WAIT_CYCLES (0..15).
// Optional feature macro DMEM_MISALIGN_CHK_EN: misaligned half/word accesses
// return rsp_err=1 with zero data and never write; without it such accesses
// are silently aligned and rsp_err stays 0.
module dmem_responder
  import core_types_pkg::*;
#(
  parameter int N_BITS      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  dmem_rsp_state_t state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;

  logic              req_mtype_reg, req_unsigned_reg;
  dmem_len_t         req_len_reg;
  logic [N_BITS-1:0] req_addr_reg, req_data_reg;

  logic      rsp_load_reg, rsp_err_reg, rsp_unsigned_reg;
  dmem_len_t rsp_len_reg;
  logic [1:0] rsp_lane_reg;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word_reg;

  logic accept, access_en;
  logic              acc_mtype, acc_unsigned, acc_err;
  dmem_len_t         acc_len;
  logic [N_BITS-1:0] acc_addr, acc_data;
  logic [1:0]        acc_lane;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [31:0] wr_data, ld_data;
  logic [3:0]  wr_be;
  logic        unused_addr_hi;

  assign bus.req_rdy = (state_reg == IDLE) || (state_reg == RESP && bus.rsp_rdy);
  assign accept      = bus.req_vld && bus.req_rdy;

  // With no wait states the access uses the request being accepted; otherwise
  // it uses the copy captured at accept, on the edge leaving WAIT.
  assign access_en = (accept && WAIT_CYCLES == 0) || (state_reg == WAIT && cnt_reg == 4'd0);

  assign acc_mtype    = (state_reg == WAIT) ? req_mtype_reg    : bus.req_mtype;
  assign acc_unsigned = (state_reg == WAIT) ? req_unsigned_reg : bus.req_unsigned;
  assign acc_len      = (state_reg == WAIT) ? req_len_reg      : bus.req_len;
  assign acc_addr     = (state_reg == WAIT) ? req_addr_reg     : bus.req_addr;
  assign acc_data     = (state_reg == WAIT) ? req_data_reg     : bus.req_data;
  assign acc_idx      = acc_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_MISALIGN_CHK_EN
  assign acc_err  = dmem_misaligned(acc_len, acc_addr[1:0]);
  assign acc_lane = acc_addr[1:0];
`else
  assign acc_err  = 1'b0;
  assign acc_lane = dmem_force_align(acc_len, acc_addr[1:0]);
`endif

  // Address bits above the array index do not take part in the access.
  assign unused_addr_hi = ^acc_addr[N_BITS-1:DEPTH_LOG2+2];

  dmem_lane_align u_lane_align (
    .st_len      (acc_len),
    .st_lane     (acc_lane),
    .st_data     (acc_data),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .ld_len      (rsp_len_reg),
    .ld_lane     (rsp_lane_reg),
    .ld_unsigned (rsp_unsigned_reg),
    .ld_word     (rd_word_reg),
    .ld_data     (ld_data)
  );

  // Storage is never reset; the rst gate keeps an access coinciding with reset
  // from landing.
  always_ff @(posedge clk) begin
    if (access_en && !rst) begin
      if (acc_mtype) begin
        if (!acc_err) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[acc_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end else begin
        rd_word_reg <= mem[acc_idx];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
          if (WAIT_CYCLES != 0) cnt_next = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      RESP: begin
        if (bus.rsp_rdy) begin
          if (accept) begin
            state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            if (WAIT_CYCLES != 0) cnt_next = WAIT_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= 4'd0;
      req_mtype_reg    <= 1'b0;
      req_unsigned_reg <= 1'b0;
      req_len_reg      <= LEN_WORD;
      req_addr_reg     <= '0;
      req_data_reg     <= '0;
      rsp_load_reg     <= 1'b0;
      rsp_err_reg      <= 1'b0;
      rsp_unsigned_reg <= 1'b0;
      rsp_len_reg      <= LEN_WORD;
      rsp_lane_reg     <= 2'b00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        req_mtype_reg    <= bus.req_mtype;
        req_unsigned_reg <= bus.req_unsigned;
        req_len_reg      <= bus.req_len;
        req_addr_reg     <= bus.req_addr;
        req_data_reg     <= bus.req_data;
      end
      // Response attributes only change on an access edge, so rsp_data and
      // rsp_err stay stable for the whole RESP phase.
      if (access_en) begin
        rsp_load_reg     <= !acc_mtype && !acc_err;
        rsp_err_reg      <= acc_err;
        rsp_unsigned_reg <= acc_unsigned;
        rsp_len_reg      <= acc_len;
        rsp_lane_reg     <= acc_lane;
      end
    end
  end

  assign bus.rsp_vld  = (state_reg == RESP);
  assign bus.rsp_data = rsp_load_reg ? ld_data : '0;
  assign bus.rsp_err  = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder with three instances
// (WAIT_CYCLES = 0, 2, 3) sharing clk and rst. Build with or without
// DMEM_MISALIGN_CHK_EN; expected values follow the macro.
module tb_dmem_responder;
  import core_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  int   seen;
  logic [31:0] exp_w4;

  always #5 clk = ~clk;

  dmem_responder_if #(.N_BITS(32)) bus0 ();
  dmem_responder_if #(.N_BITS(32)) bus2 ();
  dmem_responder_if #(.N_BITS(32)) bus3 ();

  dmem_responder #(.N_BITS(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  dmem_responder #(.N_BITS(32), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );
  dmem_responder #(.N_BITS(32), .DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  // Waits up to max falling edges for rsp_vld; lat is the edge count, 0 if never.
  task automatic wait_rsp(input int which, input int max, output int lat_o);
    lat_o = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if ((which == 0 && bus0.rsp_vld) || (which == 2 && bus2.rsp_vld) ||
          (which == 3 && bus3.rsp_vld)) begin
        lat_o = i;
        break;
      end
    end
  endtask

  // One request on the zero-wait instance with rsp_rdy high; called on a
  // falling edge, returns on the falling edge where its response is visible.
  task automatic req0(input string tag, input logic mt, input logic [1:0] len,
                      input logic uns, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_d, input logic exp_e);
    bus0.req_vld      = 1'b1;
    bus0.req_mtype    = mt;
    bus0.req_len      = len;
    bus0.req_unsigned = uns;
    bus0.req_addr     = addr;
    bus0.req_data     = data;
    #1;
    check({tag, ".rdy"}, 32'(bus0.req_rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".vld"}, 32'(bus0.rsp_vld), 32'd1);
    check({tag, ".data"}, bus0.rsp_data, exp_d);
    check({tag, ".err"}, 32'(bus0.rsp_err), 32'(exp_e));
    $display("txn %-10s %s addr=0x%08h rsp_data=0x%08h rsp_err=%0b",
             tag, mt ? "st" : "ld", addr, bus0.rsp_data, bus0.rsp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    bus0.req_vld = 0; bus0.req_mtype = 0; bus0.req_len = LEN_WORD; bus0.req_unsigned = 0;
    bus0.req_addr = 0; bus0.req_data = 0; bus0.rsp_rdy = 1;
    bus2.req_vld = 0; bus2.req_mtype = 0; bus2.req_len = LEN_WORD; bus2.req_unsigned = 0;
    bus2.req_addr = 0; bus2.req_data = 0; bus2.rsp_rdy = 1;
    bus3.req_vld = 0; bus3.req_mtype = 0; bus3.req_len = LEN_WORD; bus3.req_unsigned = 0;
    bus3.req_addr = 0; bus3.req_data = 0; bus3.rsp_rdy = 1;

    repeat (3) @(negedge clk);
    check("reset.req_rdy", 32'(bus0.req_rdy), 32'd1);
    check("reset.rsp_vld", 32'(bus0.rsp_vld), 32'd0);
    check("reset.rsp_data", bus0.rsp_data, 32'd0);
    check("reset.rsp_err", 32'(bus0.rsp_err), 32'd0);
    check("reset.rdy3", 32'(bus3.req_rdy), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back traffic on the zero-wait instance.
    req0("st_w",  1'b1, LEN_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    req0("ld_w",  1'b0, LEN_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    req0("ld_bs", 1'b0, LEN_BYTE, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    req0("ld_bu", 1'b0, LEN_BYTE, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    req0("st_h",  1'b1, LEN_HALF, 1'b0, 32'h12, 32'hABCD1234, 32'h0, 1'b0);
    req0("ld_w2", 1'b0, LEN_WORD, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
    req0("ld_hs", 1'b0, LEN_HALF, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    req0("ld_hu", 1'b0, LEN_HALF, 1'b1, 32'h12, 32'h0, 32'h00001234, 1'b0);
`ifdef DMEM_MISALIGN_CHK_EN
    req0("ld_hmis", 1'b0, LEN_HALF, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1);
    req0("st_wmis", 1'b1, LEN_WORD, 1'b0, 32'h12, 32'h99999999, 32'h0, 1'b1);
    req0("ld_w3",   1'b0, LEN_WORD, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
    exp_w4 = 32'h1234A5EF;
`else
    req0("ld_hmis", 1'b0, LEN_HALF, 1'b1, 32'h11, 32'h0, 32'h0000BEEF, 1'b0);
    req0("st_wmis", 1'b1, LEN_WORD, 1'b0, 32'h12, 32'h99999999, 32'h0, 1'b0);
    req0("ld_w3",   1'b0, LEN_WORD, 1'b0, 32'h10, 32'h0, 32'h99999999, 1'b0);
    exp_w4 = 32'h9999A599;
`endif
    req0("st_b",   1'b1, LEN_BYTE, 1'b0, 32'h11, 32'h777777A5, 32'h0, 1'b0);
    req0("ld_w4",  1'b0, LEN_WORD, 1'b0, 32'h10, 32'h0, exp_w4, 1'b0);
    req0("ld_hia", 1'b0, LEN_WORD, 1'b0, 32'hFFFFF010, 32'h0, exp_w4, 1'b0);
    bus0.req_vld = 1'b0;
    @(negedge clk);
    check("idle0.vld", 32'(bus0.rsp_vld), 32'd0);

    // Backpressure on the two-wait instance.
    bus2.req_mtype = 1'b1; bus2.req_len = LEN_WORD; bus2.req_addr = 32'h4;
    bus2.req_data = 32'h0BADF00D; bus2.req_vld = 1'b1;
    @(posedge clk); #1 bus2.req_vld = 1'b0;
    wait_rsp(2, 10, lat);
    check("bp.st.lat", 32'(lat), 32'd3);
    check("bp.st.data", bus2.rsp_data, 32'd0);
    $display("txn bp.st      st addr=0x00000004 lat=%0d", lat);
    @(negedge clk);
    bus2.rsp_rdy = 1'b0;
    bus2.req_mtype = 1'b0; bus2.req_len = LEN_WORD; bus2.req_addr = 32'h4; bus2.req_vld = 1'b1;
    @(posedge clk); #1 bus2.req_vld = 1'b0;
    wait_rsp(2, 10, lat);
    check("bp.ld.lat", 32'(lat), 32'd3);
    bus2.req_len = LEN_BYTE; bus2.req_unsigned = 1'b1; bus2.req_addr = 32'h5; bus2.req_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp.hold.vld", 32'(bus2.rsp_vld), 32'd1);
      check("bp.hold.data", bus2.rsp_data, 32'h0BADF00D);
      check("bp.hold.rdy", 32'(bus2.req_rdy), 32'd0);
    end
    $display("txn bp.ld      ld addr=0x00000004 rsp_data=0x%08h held 5 cycles", bus2.rsp_data);
    @(negedge clk);
    bus2.rsp_rdy = 1'b1;
    #1 check("bp.rel.rdy", 32'(bus2.req_rdy), 32'd1);
    @(posedge clk); #1 bus2.req_vld = 1'b0;
    wait_rsp(2, 10, lat);
    check("bp.next.lat", 32'(lat), 32'd3);
    check("bp.next.data", bus2.rsp_data, 32'h000000F0);
    $display("txn bp.next    ld addr=0x00000005 rsp_data=0x%08h lat=%0d", bus2.rsp_data, lat);
    @(negedge clk);
    check("bp.idle.vld", 32'(bus2.rsp_vld), 32'd0);

    // Reset in the middle of WAIT on the three-wait instance.
    bus3.req_mtype = 1'b1; bus3.req_len = LEN_WORD; bus3.req_addr = 32'h20;
    bus3.req_data = 32'hCAFEF00D; bus3.req_vld = 1'b1;
    @(posedge clk); #1 bus3.req_vld = 1'b0;
    wait_rsp(3, 10, lat);
    check("rw.st.lat", 32'(lat), 32'd4);
    $display("txn rw.st      st addr=0x00000020 lat=%0d", lat);
    @(negedge clk);
    bus3.req_data = 32'h11111111; bus3.req_vld = 1'b1;
    @(posedge clk); #1 bus3.req_vld = 1'b0;
    @(negedge clk);
    check("rw.wait.rdy", 32'(bus3.req_rdy), 32'd0);
    rst = 1'b1;
    #1;
    check("rw.rst.vld", 32'(bus3.rsp_vld), 32'd0);
    check("rw.rst.rdy", 32'(bus3.req_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus3.rsp_vld) seen++;
    end
    check("rw.no_rsp", 32'(seen), 32'd0);
    $display("txn rw.abort   st addr=0x00000020 abandoned, responses seen=%0d", seen);
    bus3.req_mtype = 1'b0; bus3.req_vld = 1'b1;
    @(posedge clk); #1 bus3.req_vld = 1'b0;
    wait_rsp(3, 10, lat);
    check("rw.ld.lat", 32'(lat), 32'd4);
    check("rw.ld.data", bus3.rsp_data, 32'hCAFEF00D);
    $display("txn rw.ld      ld addr=0x00000020 rsp_data=0x%08h lat=%0d", bus3.rsp_data, lat);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
